// File: rtl/dmem_io_arbiter_if.sv
// dmem_io_arbiter_if: requester ports plus Data-Memory and IO bus of the dmem/IO arbiter.
// master = requesters and peripherals, slave = the arbiter.
interface dmem_io_arbiter_if;
    logic        req0, we0, ack0, stall0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        req1, we1, ack1, lock1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        io_sel, io_we, io_ready, bus_err;
    logic [31:0] io_addr, io_wdata;
    logic [23:0] io_rdata;
    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, lock1,
               mem_rdata, io_rdata, io_ready,
        input  ack0, stall0, rdata0, ack1, rdata1, mem_en, mem_we, mem_addr, mem_wdata,
               io_sel, io_we, io_addr, io_wdata, bus_err
    );
    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, lock1,
               mem_rdata, io_rdata, io_ready,
        output ack0, stall0, rdata0, ack1, rdata1, mem_en, mem_we, mem_addr, mem_wdata,
               io_sel, io_we, io_addr, io_wdata, bus_err
    );
endinterface

// File: rtl/dmem_io_arbiter.sv
// dmem_io_arbiter: shares the Data-Memory/IO bus between the CPU (port 0) and the loader (port 1).
// Round-robin with a port 1 lock; BRAM has one-cycle read latency, IO waits on io_ready with a timeout.
module dmem_io_arbiter #(
    parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
    parameter int          TIMEOUT = 15
) (
    input logic              clock,
    input logic              reset,
    dmem_io_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      state, state_nx;
    logic        rr_last, gnt, gnt_nx, we_q, err, is_io, tmo, acc_mem, acc_io, resp0, resp1;
    logic [31:0] addr_q, wdata_q, rdata0_q, rdata1_q, resp_data;
    logic [23:0] io_q;
    logic [3:0]  wait_cnt;
    always_comb begin
        is_io = addr_q >= IO_BASE;
        gnt_nx = (bus.lock1 && bus.req1) ? 1'b1 : (bus.req0 && bus.req1) ? ~rr_last : bus.req1;
        tmo = state == ACCESS && is_io && !bus.io_ready && wait_cnt == 4'(TIMEOUT);
        state_nx = state == IDLE   ? ((bus.req0 || bus.req1) ? ACCESS : IDLE)
                 : state == ACCESS ? ((!is_io || bus.io_ready || tmo) ? RESP : ACCESS)
                 : IDLE;
        acc_mem = state == ACCESS && !is_io;
        acc_io = state == ACCESS && is_io;
        resp0 = state == RESP && !gnt;
        resp1 = state == RESP && gnt;
        // read data is presented combinationally in RESP so it lines up with the ack
        resp_data = we_q ? 32'h0 : is_io ? {8'h0, io_q} : bus.mem_rdata;
        bus.mem_en = acc_mem;
        bus.mem_we = acc_mem && we_q;
        bus.mem_addr = addr_q;
        bus.mem_wdata = wdata_q;
        bus.io_sel = acc_io;
        bus.io_we = acc_io && we_q;
        bus.io_addr = addr_q;
        bus.io_wdata = wdata_q;
        bus.ack0 = resp0;
        bus.ack1 = resp1;
        bus.stall0 = bus.req0 && !resp0;
        bus.rdata0 = resp0 ? resp_data : rdata0_q;
        bus.rdata1 = resp1 ? resp_data : rdata1_q;
        bus.bus_err = state == RESP && err;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rr_last <= 1'b1;
            gnt <= 1'b0;
            we_q <= 1'b0;
            addr_q <= 32'h0;
            wdata_q <= 32'h0;
            io_q <= 24'h0;
            wait_cnt <= 4'h0;
            err <= 1'b0;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (bus.req0 || bus.req1)) begin
                gnt <= gnt_nx;
                rr_last <= gnt_nx;
                we_q <= gnt_nx ? bus.we1 : bus.we0;
                addr_q <= gnt_nx ? bus.addr1 : bus.addr0;
                wdata_q <= gnt_nx ? bus.wdata1 : bus.wdata0;
            end
            if (state == ACCESS) begin
                io_q <= bus.io_rdata;
                if (acc_io && !bus.io_ready && !tmo) wait_cnt <= wait_cnt + 4'd1;
                if (tmo) err <= 1'b1;
            end
            if (state == RESP) begin
                err <= 1'b0;
                wait_cnt <= 4'h0;
                if (resp0) rdata0_q <= resp_data;
                if (resp1) rdata1_q <= resp_data;
            end
        end
    end
endmodule

// File: tb/tb_dmem_io_arbiter.sv
// tb_dmem_io_arbiter: directed and randomized checks of dmem_io_arbiter against a transaction-level model
// with a golden memory image, round-robin/lock grant prediction and per-access latency from the bus rules.
module tb_dmem_io_arbiter;
    localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] bram [0:255];
    logic [31:0] gmem [0:255];
    int          io_delay = 0;
    int          io_cnt = 0;
    logic [23:0] io_key = 24'h5A3C96;
    bit          rr_model = 1'b1;
    dmem_io_arbiter_if bus();
    dmem_io_arbiter #(.IO_BASE(IO_BASE), .TIMEOUT(15)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    // BRAM with one-cycle read latency, and an IO peripheral answering io_delay cycles into the access
    always @(posedge clock) begin
        if (bus.mem_en) begin
            if (bus.mem_we) bram[bus.mem_addr[9:2]] <= bus.mem_wdata;
            bus.mem_rdata <= bram[bus.mem_addr[9:2]];
        end
        io_cnt <= bus.io_sel ? io_cnt + 1 : 0;
    end
    assign bus.io_ready = bus.io_sel && io_cnt == io_delay;
    assign bus.io_rdata = bus.io_addr[23:0] ^ io_key;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    always @(negedge clock) begin
        if (!reset) begin
            check("one_strobe", 32'(bus.mem_en & bus.io_sel), 32'h0);
            check("one_ack", 32'(bus.ack0 & bus.ack1), 32'h0);
        end
    end
    function automatic int acc_cycles(input logic [31:0] a);
        if (a < IO_BASE) return 1;
        return io_delay > 15 ? 16 : io_delay + 1;
    endfunction
    function automatic logic [31:0] rand_addr();
        logic [31:0] off;
        off = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        return $urandom_range(0, 3) == 0 ? IO_BASE + off : off;
    endfunction
    // raise the given requests together and check every cycle until the last predicted ack
    task automatic run(input bit r0, input bit r1, input bit lk, input bit w0, input bit w1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
        logic [31:0] a [2];
        logic [31:0] d [2];
        logic [31:0] exp_rd [2];
        logic [31:0] wa, wd;
        bit          w [2];
        bit          req [2];
        bit          exp_err [2];
        bit          io [2];
        bit          want_mem, want_io, ww;
        int          k_start [2];
        int          k_ack [2];
        int          kmax, p;
        a = '{a0, a1};
        d = '{d0, d1};
        w = '{w0, w1};
        req = '{r0, r1};
        io = '{a0 >= IO_BASE, a1 >= IO_BASE};
        exp_err = '{1'b0, 1'b0};
        exp_rd = '{32'h0, 32'h0};
        k_start = '{-10, -10};
        k_ack = '{-10, -10};
        kmax = 0;
        p = 0;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) p = (r0 && r1) ? (lk ? 1 : (rr_model ? 0 : 1)) : (r1 ? 1 : 0);
            else p = 1 - p;
            if (!req[p]) continue;
            k_start[p] = kmax == 0 ? 1 : kmax + 2;
            k_ack[p] = k_start[p] + acc_cycles(a[p]);
            kmax = k_ack[p];
            exp_err[p] = io[p] && io_delay > 15;
            exp_rd[p] = w[p] ? 32'h0 : io[p] ? {8'h0, a[p][23:0] ^ io_key} : gmem[a[p][9:2]];
            if (w[p] && !io[p]) gmem[a[p][9:2]] = d[p];
            rr_model = p == 1;
        end
        @(negedge clock);
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        bus.lock1 = lk;
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clock);
            want_mem = 1'b0; want_io = 1'b0; ww = 1'b0; wa = 32'h0; wd = 32'h0;
            for (int q = 0; q < 2; q++) begin
                if (req[q] && k >= k_start[q] && k < k_ack[q]) begin
                    want_mem = !io[q]; want_io = io[q]; ww = w[q]; wa = a[q]; wd = d[q];
                end
            end
            check("mem_en", bus.mem_en, want_mem);
            check("io_sel", bus.io_sel, want_io);
            check("mem_we", bus.mem_we, want_mem && ww);
            check("io_we", bus.io_we, want_io && ww);
            if (want_mem) check("mem_addr", bus.mem_addr, wa);
            if (want_io) check("io_addr", bus.io_addr, wa);
            if (want_mem && ww) check("mem_wdata", bus.mem_wdata, wd);
            if (want_io && ww) check("io_wdata", bus.io_wdata, wd);
            check("ack0", bus.ack0, req[0] && k == k_ack[0]);
            check("ack1", bus.ack1, req[1] && k == k_ack[1]);
            check("stall0", bus.stall0, req[0] && k < k_ack[0]);
            check("bus_err", bus.bus_err, (req[0] && k == k_ack[0] && exp_err[0]) ||
                                          (req[1] && k == k_ack[1] && exp_err[1]));
            if (req[0] && k == k_ack[0]) begin
                check("rdata0", bus.rdata0, exp_rd[0]);
                bus.req0 = 1'b0;
            end
            if (req[1] && k == k_ack[1]) begin
                check("rdata1", bus.rdata1, exp_rd[1]);
                bus.req1 = 1'b0;
            end
        end
        bus.lock1 = 1'b0;
        @(negedge clock);
        if (r0) check("rdata0_hold", bus.rdata0, exp_rd[0]);
        if (r1) check("rdata1_hold", bus.rdata1, exp_rd[1]);
    endtask
    initial begin
        logic [31:0] v;
        int          nb, nw, sel;
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0; bus.lock1 = 0;
        for (int i = 0; i < 256; i++) begin
            v = i == 4 ? 32'hDEADBEEF : $urandom;
            bram[i] <= v;
            gmem[i] = v;
        end
        repeat (3) @(negedge clock);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_io_sel", bus.io_sel, 0);
        check("rst_io_we", bus.io_we, 0);
        check("rst_ack0", bus.ack0, 0);
        check("rst_ack1", bus.ack1, 0);
        check("rst_stall0", bus.stall0, 0);
        check("rst_rdata0", bus.rdata0, 0);
        check("rst_rdata1", bus.rdata1, 0);
        check("rst_bus_err", bus.bus_err, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        reset = 1'b0;
        run(1, 0, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0);
        check("bram_read", bus.rdata0, 32'hDEADBEEF);
        repeat (4) run(1, 1, 0, 0, 1, 32'h20, 32'h24, 32'h0, $urandom);
        // locked loader burst: four port 1 writes complete before the pending port 0 read
        @(negedge clock);
        bus.lock1 = 1; bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h3C;
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 32'h30; bus.wdata1 = 32'hC0DE0000;
        nb = 0;
        nw = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clock);
            if (bus.mem_we) begin
                check("burst_wdata", bus.mem_wdata, 32'hC0DE0000 + nw);
                nw++;
            end
            check("burst_ack1", bus.ack1, k % 3 == 2 && k <= 11);
            check("burst_ack0", bus.ack0, k == 14);
            check("burst_stall0", bus.stall0, k < 14);
            if (bus.ack1) begin
                nb++;
                bus.addr1 = 32'h30 + 4 * nb;
                bus.wdata1 = 32'hC0DE0000 + nb;
                if (nb == 4) bus.req1 = 0;
            end
            if (k == 14) begin
                check("burst_rdata0", bus.rdata0, 32'hC0DE0003);
                bus.req0 = 0;
            end
        end
        check("burst_writes", nw, 4);
        bus.lock1 = 0;
        bus.req1 = 0;
        for (int i = 0; i < 4; i++) gmem[12 + i] = 32'hC0DE0000 + i;
        rr_model = 0;
        io_key = 24'hFFFC70 ^ 24'hABCDEF;
        io_delay = 3;
        run(1, 0, 0, 0, 0, 32'hFFFF_FC70, 32'h0, 32'h0, 32'h0);
        check("io_read", bus.rdata0, 32'h00ABCDEF);
        io_key = 24'h5A3C96;
        io_delay = 99;
        run(1, 0, 0, 1, 0, IO_BASE + 32'h8, 32'h0, 32'h12345678, 32'h0);
        io_delay = 0;
        run(0, 1, 0, 0, 0, 32'h0, 32'h44, 32'h0, 32'h0);
        // reset in the middle of a stalled IO write
        io_delay = 99;
        @(negedge clock);
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = IO_BASE + 32'h10; bus.wdata0 = 32'h0BADF00D;
        repeat (3) @(negedge clock);
        check("pre_rst_io_sel", bus.io_sel, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_io_sel", bus.io_sel, 0);
        check("mid_rst_io_we", bus.io_we, 0);
        check("mid_rst_ack0", bus.ack0, 0);
        bus.req0 = 0;
        @(negedge clock);
        check("post_rst_ack0", bus.ack0, 0);
        reset = 1'b0;
        rr_model = 1;
        io_delay = 1;
        run(1, 1, 0, 1, 0, 32'h50, IO_BASE + 32'h20, $urandom, 32'h0);
        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 9);
            io_delay = sel < 6 ? $urandom_range(0, 4) : sel < 8 ? $urandom_range(14, 17) : 99;
            run(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 3) != 0),
                bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                rand_addr(), rand_addr(), $urandom, $urandom);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
